sd_sec_rw_test: RTL
===================

# sd_sec_rw_test

Self-checking single-sector read/write exerciser for the TF-card SPI controller (`sd_card_top`). It drives that controller's sector write and sector read handshakes. It writes a deterministic 512-byte pattern to one sector, reads the sector back, compares every byte, and reports pass/fail, an error count and a timeout flag. The results can drive the board-test LEDs or UART.

## Interface
Parameters:
- `SEC_ADDR`, 32'd2048: sector address that is written and read back.
- `SEED`, 8'hA5: pattern seed.
- `TIMEOUT`, 24'd10_000_000: maximum number of cycles allowed per WRITE or READ phase.

Ports:
- `sys_clk`, in, 1: single clock, the same clock as `sd_card_top`.
- `sys_rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: a one-cycle pulse that launches a test run.
- `sd_init_done`, in, 1: card-initialised level from `sd_card_top`.
- `sd_sec_write`, out, 1: write request level.
- `sd_sec_write_addr`, out, 32: write sector address.
- `sd_sec_write_data`, out, 8: write byte.
- `sd_sec_write_data_req`, in, 1: one-cycle pulse; the controller consumes the current byte.
- `sd_sec_write_end`, in, 1: one-cycle pulse; the write has completed.
- `sd_sec_read`, out, 1: read request level.
- `sd_sec_read_addr`, out, 32: read sector address.
- `sd_sec_read_data`, in, 8: read byte.
- `sd_sec_read_data_valid`, in, 1: one-cycle strobe; `sd_sec_read_data` is valid.
- `sd_sec_read_end`, in, 1: one-cycle pulse; the read has completed.
- `busy`, out, 1: high from accepted start until DONE.
- `done`, out, 1: one-cycle pulse when a run finishes.
- `pass`, out, 1: result of the last run; held until the next accepted start.
- `err_cnt`, out, 10: number of mismatched bytes in the last run (0..512).
- `timeout`, out, 1: the last run aborted on the watchdog.
- `len_err`, out, 1: the last read did not deliver exactly 512 strobes before `sd_sec_read_end`.

## Operation
- **Pattern:** byte i (0..511) = `i[7:0] ^ SEED ^ {7'b0, i[8]}`. All arithmetic is on a 10-bit index counter.
- **FSM states:** IDLE, WAIT_INIT, WRITE, READ, DONE.
- **IDLE:** a `start` pulse moves the FSM to WAIT_INIT. On that transition:
  - `err_cnt`, `timeout`, `len_err` and `pass` are cleared.
  - `busy` is set.
  - the write and read indices are set to 0.
- **WAIT_INIT:** waits for `sd_init_done`=1, then moves to WRITE. No watchdog runs here.
- **WRITE:**
  - `sd_sec_write`=1, `sd_sec_write_addr`=SEC_ADDR.
  - `sd_sec_write_data` is the pattern byte at the write index.
  - Each `sd_sec_write_data_req` advances the write index; `sd_sec_write_data` shows the next byte from the following cycle.
  - Index wraps 511→0; extra requests beyond 512 are tolerated.
  - `sd_sec_write_end` → READ.
- **READ:**
  - `sd_sec_read`=1, `sd_sec_read_addr`=SEC_ADDR.
  - On each `sd_sec_read_data_valid` with read index < 512: compare against the pattern byte at the read index; on mismatch, `err_cnt`+1. Then the read index +1.
  - Strobes with read index ≥ 512 are not compared; the index saturates at 512 and `len_err` is set.
  - `sd_sec_read_end` → DONE, with `len_err` |= (read index != 512).
  - A data strobe coincident with `sd_sec_read_end` is still compared.
- **Watchdog:** a cycle counter clears on entry to WRITE and on entry to READ. If it reaches TIMEOUT−1 in either state: `timeout`=1, and the FSM moves to DONE. `sd_sec_write` and `sd_sec_read` drop when the FSM leaves their states.
- **DONE:**
  - `done` pulses for one cycle.
  - `pass` = (`err_cnt`==0) & !`timeout` & !`len_err`.
  - `busy`=0.
  - FSM → IDLE.
- A `start` pulse while `busy`=1 is ignored.
- Addresses are constant SEC_ADDR in all states.

## Timing
- **Reset values:** FSM=IDLE; `sd_sec_write`=0; `sd_sec_read`=0; `sd_sec_write_data`=8'h00 (then the pattern byte 0 = SEED once in WRITE); `busy`=0; `done`=0; `pass`=0; `err_cnt`=0; `timeout`=0; `len_err`=0.
- **Reset mid-run:** `sd_sec_write` and `sd_sec_read` deassert on the cycle after `sys_rst_n` is sampled low; all results clear.
- All outputs are registered. `sd_sec_write` rises 1 cycle after the FSM samples `sd_init_done`=1 in WAIT_INIT.
- `sd_sec_write` falls, and `sd_sec_read` rises, on the cycle after `sd_sec_write_end`.
- `sd_sec_read` falls on the cycle after `sd_sec_read_end`.
- `done` asserts 2 cycles after `sd_sec_read_end` (through DONE); `err_cnt` is final by then.
- If `start` arrives with `sd_init_done` already high, `sd_sec_write` rises 2 cycles after `start`.

## Test plan
- **Clean run:** `sd_init_done`=1, `start`; the model issues 512 requests, echoes the bytes back on 512 strobes, then the end pulses → `done` pulses, `pass`=1, `err_cnt`=0, `timeout`=0, `len_err`=0. The model captures write byte 0 = 8'hA5, byte 256 = 8'hA4, byte 511 = 8'h5B.
- **Corrupted read:** the model flips bits of bytes 3 and 400 → `err_cnt`=2, `pass`=0.
- **Short read:** the model gives 500 strobes then `sd_sec_read_end` → `len_err`=1, `pass`=0, `err_cnt`=0.
- **Watchdog:** TIMEOUT=1000; `sd_sec_write_end` is never sent → `timeout`=1 about 1000 cycles after WRITE entry; `sd_sec_write` falls; `pass`=0; `sd_sec_read` never rises.
- **Init wait and ignored start:**
  - `sd_init_done`=0 for 5000 cycles after `start` → `busy`=1 and no request is issued.
  - A second `start` during the run has no effect.
  - The run completes with `pass`=1 after `sd_init_done` rises.
- **Reset mid-READ:** `sys_rst_n` low for 1 cycle after 100 strobes → all outputs return to their reset values. A fresh `start` then yields `pass`=1.

Source files
------------

// File: rtl/sd_sec_rw_test_if.sv
// Sector read/write handshake between the exerciser (master) and the TF-card SPI controller (slave).
// Request levels and data flow one way; the controller paces them with req/valid/end strobes.
interface sd_sec_rw_test_if;
    logic        sd_init_done;
    logic        sd_sec_write;
    logic [31:0] sd_sec_write_addr;
    logic [7:0]  sd_sec_write_data;
    logic        sd_sec_write_data_req;
    logic        sd_sec_write_end;
    logic        sd_sec_read;
    logic [31:0] sd_sec_read_addr;
    logic [7:0]  sd_sec_read_data;
    logic        sd_sec_read_data_valid;
    logic        sd_sec_read_end;

    modport master (
        input  sd_init_done,
        output sd_sec_write,
        output sd_sec_write_addr,
        output sd_sec_write_data,
        input  sd_sec_write_data_req,
        input  sd_sec_write_end,
        output sd_sec_read,
        output sd_sec_read_addr,
        input  sd_sec_read_data,
        input  sd_sec_read_data_valid,
        input  sd_sec_read_end
    );

    modport slave (
        output sd_init_done,
        input  sd_sec_write,
        input  sd_sec_write_addr,
        input  sd_sec_write_data,
        output sd_sec_write_data_req,
        output sd_sec_write_end,
        input  sd_sec_read,
        input  sd_sec_read_addr,
        output sd_sec_read_data,
        output sd_sec_read_data_valid,
        output sd_sec_read_end
    );
endinterface

// File: rtl/sd_sec_rw_test.sv
// Writes a seeded 512-byte pattern to one sector, reads it back and reports pass/err_cnt/timeout/len_err.
// All outputs registered; the controller fully paces the data via req/valid strobes, guarded by a per-phase watchdog.
module sd_sec_rw_test #(
    parameter logic [31:0] SEC_ADDR = 32'd2048,
    parameter logic [7:0]  SEED     = 8'hA5,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    sd_sec_rw_test_if.master sd,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [9:0]       err_cnt,
    output logic             timeout,
    output logic             len_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  wr_idx_q, wr_idx_d;
    logic [9:0]  rd_idx_q, rd_idx_d;
    logic [23:0] wdog_q, wdog_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic [7:0]  wr_dat_q, wr_dat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [9:0]  err_cnt_q, err_cnt_d;
    logic        timeout_q, timeout_d;
    logic        len_err_q, len_err_d;

    // Bit 8 of the index is folded in so the second half of the sector differs from the first.
    function automatic logic [7:0] pattern(input logic [8:0] idx);
        return idx[7:0] ^ SEED ^ {7'b0, idx[8]};
    endfunction

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        wdog_d    = wdog_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        timeout_d = timeout_q;
        len_err_d = len_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_INIT;
                    err_cnt_d = 10'd0;
                    timeout_d = 1'b0;
                    len_err_d = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    wr_idx_d  = 10'd0;
                    rd_idx_d  = 10'd0;
                end
            end
            WAIT_INIT: begin
                if (sd.sd_init_done) begin
                    state_d = WRITE;
                    wdog_d  = 24'd0;
                end
            end
            WRITE: begin
                if (sd.sd_sec_write_data_req) begin
                    wr_idx_d = (wr_idx_q == 10'd511) ? 10'd0 : wr_idx_q + 10'd1;
                end
                if (sd.sd_sec_write_end) begin
                    state_d = READ;
                    wdog_d  = 24'd0;
                end else if (wdog_q == TIMEOUT - 24'd1) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            READ: begin
                if (sd.sd_sec_read_data_valid) begin
                    if (rd_idx_q < 10'd512) begin
                        if (sd.sd_sec_read_data != pattern(rd_idx_q[8:0])) begin
                            err_cnt_d = err_cnt_q + 10'd1;
                        end
                        rd_idx_d = rd_idx_q + 10'd1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
                // Uses the post-strobe index so a strobe coincident with the end pulse counts.
                if (sd.sd_sec_read_end) begin
                    state_d = DONE;
                    if (rd_idx_d != 10'd512) begin
                        len_err_d = 1'b1;
                    end
                end else if (wdog_q == TIMEOUT - 24'd1) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 10'd0) && !timeout_q && !len_err_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_req_d = (state_d == WRITE);
        rd_req_d = (state_d == READ);
        wr_dat_d = (state_d == WRITE) ? pattern(wr_idx_d[8:0]) : wr_dat_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            wr_idx_q  <= 10'd0;
            rd_idx_q  <= 10'd0;
            wdog_q    <= 24'd0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_dat_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 10'd0;
            timeout_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wdog_q    <= wdog_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_dat_q  <= wr_dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            timeout_q <= timeout_d;
            len_err_q <= len_err_d;
        end
    end

    assign sd.sd_sec_write      = wr_req_q;
    assign sd.sd_sec_write_addr = SEC_ADDR;
    assign sd.sd_sec_write_data = wr_dat_q;
    assign sd.sd_sec_read       = rd_req_q;
    assign sd.sd_sec_read_addr  = SEC_ADDR;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pass                 = pass_q;
    assign err_cnt              = err_cnt_q;
    assign timeout              = timeout_q;
    assign len_err              = len_err_q;

endmodule
